// File: rtl/clk_wiz_vio.sv
// Clock divider with lock detect, plus a probe-capture debug block read through a small register port.
module clk_wiz_vio #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned PROBE_W     = 32
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  output logic               w_clk_out,
  output logic               w_locked,
  output logic               w_ce_rise,
  input  logic [PROBE_W-1:0] w_probe_in,
  input  logic               w_dbg_hold,
  input  logic [1:0]         w_dbg_addr,
  output logic [31:0]        w_dbg_rdata,
  output logic [3:0]         w_led
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_CYCLES);
  localparam logic [31:0]      ID_WORD  = 32'h5649_4F30;

  logic [CNT_W-1:0] div_cnt;
  logic [LCK_W-1:0] lock_cnt;
  logic [31:0]      cap;
  logic [31:0]      chg_cnt;
  logic             wrap_c;
  logic             rise_c;
  logic [31:0]      probe_ext_c;

  // Rise event: the edge on which the divided clock goes 0 -> 1.
  assign wrap_c      = (div_cnt == CNT_LAST);
  assign rise_c      = wrap_c & ~w_clk_out;
  assign probe_ext_c = 32'(w_probe_in);

  // Half-period counter; wrap toggles the output clock and flags the rising half.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      div_cnt   <= '0;
      w_clk_out <= 1'b0;
      w_ce_rise <= 1'b0;
    end else begin
      w_ce_rise <= rise_c;
      if (wrap_c) begin
        div_cnt   <= '0;
        w_clk_out <= ~w_clk_out;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  // Saturating rise counter; lock is sticky once the count reaches its limit.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      lock_cnt <= '0;
      w_locked <= 1'b0;
    end else if (rise_c && (lock_cnt != LCK_MAX)) begin
      lock_cnt <= lock_cnt + LCK_W'(1);
      if (lock_cnt == LCK_MAX - LCK_W'(1)) begin
        w_locked <= 1'b1;
      end
    end
  end

  // Probe capture on rise events; changes are counted only once locked, compared to the pre-edge sample.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cap     <= '0;
      chg_cnt <= '0;
    end else if (rise_c && !w_dbg_hold) begin
      cap <= probe_ext_c;
      if (w_locked && (probe_ext_c != cap) && (chg_cnt != 32'hFFFF_FFFF)) begin
        chg_cnt <= chg_cnt + 32'd1;
      end
    end
  end

  // Byte-parity LEDs, one cycle behind the captured word.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_led <= 4'b0000;
    end else begin
      w_led <= {^cap[31:24], ^cap[23:16], ^cap[15:8], ^cap[7:0]};
    end
  end

  // Debug register read mux.
  always_comb begin
    w_dbg_rdata = '0;
    case (w_dbg_addr)
      2'd0: w_dbg_rdata = cap;
      2'd1: w_dbg_rdata = chg_cnt;
      2'd2: w_dbg_rdata = {29'b0, w_dbg_hold, w_clk_out, w_locked};
      2'd3: w_dbg_rdata = ID_WORD;
      default: w_dbg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_clk_wiz_vio.sv
// Directed bench: one divide-by-2 instance (16-bit probe) and one divide-by-6 instance with quick lock.
module tb_clk_wiz_vio;

  logic        clk;
  logic        rst_n;
  logic [31:0] probe;
  logic        hold;
  logic [1:0]  addr;

  logic        clk_out_a, locked_a, ce_a;
  logic [31:0] rdata_a;
  logic [3:0]  led_a;
  logic        clk_out_b, locked_b, ce_b;
  logic [31:0] rdata_b;
  logic [3:0]  led_b;

  int errors = 0;
  int checks = 0;

  clk_wiz_vio #(.HALF_PERIOD(1), .LOCK_CYCLES(16), .PROBE_W(16)) u_dut_a (
    .w_clk(clk), .w_rst_n(rst_n), .w_clk_out(clk_out_a), .w_locked(locked_a),
    .w_ce_rise(ce_a), .w_probe_in(probe[15:0]), .w_dbg_hold(hold),
    .w_dbg_addr(addr), .w_dbg_rdata(rdata_a), .w_led(led_a)
  );

  clk_wiz_vio #(.HALF_PERIOD(3), .LOCK_CYCLES(4), .PROBE_W(32)) u_dut_b (
    .w_clk(clk), .w_rst_n(rst_n), .w_clk_out(clk_out_b), .w_locked(locked_b),
    .w_ce_rise(ce_b), .w_probe_in(probe), .w_dbg_hold(hold),
    .w_dbg_addr(addr), .w_dbg_rdata(rdata_b), .w_led(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next rise event of instance b, bounded.
  task automatic wait_rise_b();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ce_b) seen = 1'b1;
    end
    check("rise_seen_b", 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    probe = 32'h0;
    hold  = 1'b0;
    addr  = 2'd0;
    #2;
    check("rst_clk_out_a", 32'(clk_out_a), 32'd0);
    check("rst_locked_b", 32'(locked_b), 32'd0);
    check("rst_ce_b", 32'(ce_b), 32'd0);
    check("rst_led_b", 32'(led_b), 32'd0);
    check("rst_addr0_b", rdata_b, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running divider and lock timing on both instances.
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (k <= 8) begin
        check($sformatf("a_clk_out_e%0d", k), 32'(clk_out_a), 32'(k % 2));
        check($sformatf("a_ce_e%0d", k), 32'(ce_a), 32'(k % 2));
      end
      check($sformatf("b_clk_out_e%0d", k), 32'(clk_out_b), 32'((k / 3) % 2));
      check($sformatf("b_ce_e%0d", k), 32'(ce_b), 32'(k % 6 == 3));
      check($sformatf("b_locked_e%0d", k), 32'(locked_b), 32'(k >= 21));
      if (k == 30 || k == 31) begin
        check($sformatf("a_locked_e%0d", k), 32'(locked_a), 32'(k >= 31));
      end
    end
    addr = 2'd1; #1;
    check("b_cnt_after_lock", rdata_b, 32'd0);

    // Two distinct probe values after lock.
    probe = 32'h0000_00FF;
    wait_rise_b();
    addr = 2'd0; #1;
    check("t3_addr0_ff", rdata_b, 32'h0000_00FF);
    addr = 2'd1; #1;
    check("t3_cnt1", rdata_b, 32'd1);
    @(posedge clk); #1;
    check("t3_led_ff", 32'(led_b), 32'h0);
    probe = 32'h0102_0304;
    wait_rise_b();
    addr = 2'd0; #1;
    check("t3_addr0_0102", rdata_b, 32'h0102_0304);
    addr = 2'd1; #1;
    check("t3_cnt2", rdata_b, 32'd2);
    @(posedge clk); #1;
    // byte parities: 01->1, 02->1, 03->0, 04->1
    check("t3_led_0102", 32'(led_b), 32'(4'b1101));

    // Hold raised mid-period freezes capture at the next rise event.
    hold  = 1'b1;
    probe = 32'h1234_5678;
    wait_rise_b();
    addr = 2'd0; #1;
    check("t4_hold_addr0", rdata_b, 32'h0102_0304);
    addr = 2'd1; #1;
    check("t4_hold_cnt", rdata_b, 32'd2);
    addr = 2'd2; #1;
    check("t4_status", rdata_b, 32'h0000_0007);
    hold = 1'b0;
    wait_rise_b();
    addr = 2'd0; #1;
    check("t4_rel_addr0", rdata_b, 32'h1234_5678);
    addr = 2'd1; #1;
    check("t4_rel_cnt", rdata_b, 32'd3);
    @(posedge clk); #1;
    // byte parities: 12->0, 34->1, 56->0, 78->0
    check("t4_led", 32'(led_b), 32'(4'b0100));
    addr = 2'd0; #1;
    check("a_probe16_addr0", rdata_a, 32'h0000_5678);

    // Stable probe: counter must not move.
    addr = 2'd1;
    for (int r = 0; r < 10; r++) begin
      wait_rise_b();
      check($sformatf("t6_cnt_r%0d", r), rdata_b, 32'd3);
    end

    // Asynchronous reset mid-period.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_locked_b", 32'(locked_b), 32'd0);
    check("t5_locked_a", 32'(locked_a), 32'd0);
    check("t5_clk_out_b", 32'(clk_out_b), 32'd0);
    check("t5_led_b", 32'(led_b), 32'd0);
    addr = 2'd0; #1;
    check("t5_addr0", rdata_b, 32'd0);
    addr = 2'd1; #1;
    check("t5_addr1", rdata_b, 32'd0);
    addr = 2'd3; #1;
    check("t5_addr3", rdata_b, 32'h5649_4F30);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t5_restart_e%0d", k), 32'(clk_out_b), 32'(k >= 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
